// File: rtl/qam_uart_pkg.sv
// rtl/qam_uart_pkg.sv - shared constants, FSM state type and sample sign-extension helper
//
// Purpose : common definitions for the I/Q UART framer and its byte shifter.
// Contents: SYNC_BYTE       - first byte of every frame
//           BYTES_PER_FRAME - sync + I hi/lo + Q hi/lo
//           tx_state_e      - serial FSM states (IDLE, START, DATA, STOP)
//           sext16()        - sign-extends the low w bits of a value to 16 bits
package qam_uart_pkg;

   localparam logic [7:0] SYNC_BYTE       = 8'hA5;
   localparam int         BYTES_PER_FRAME = 5;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   // Bits at or above position w are replaced by copies of bit w-1.
   function automatic logic [15:0] sext16(input logic [15:0] v, input int w);
      logic [15:0] r;
      logic [3:0]  msb;
      msb = 4'(w - 1);
      for (int b = 0; b < 16; b++) begin
         r[b] = (b < w) ? v[b] : v[msb];
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 serialiser for one byte, chainable without inter-byte gaps
//
// Purpose : shifts one byte out as start bit, 8 data bits LSB first, stop bit,
//           each bit lasting CLKS_PER_BIT cycles.
// Ports   : clk     - system clock
//           reset   - synchronous active-high reset
//           start   - load byte_in; honoured in IDLE and in the last cycle of STOP
//           byte_in - byte to send
//           tx      - registered serial line, idles high
//           done    - high in the last cycle of the stop bit
//           state   - current FSM state
module uart_tx_byte
   import qam_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       done,
   output tx_state_e  state
);

   localparam int             DW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLKS_PER_BIT - 1);

   tx_state_e     state_q;
   logic [DW-1:0] div_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          tx_q;
   logic          bit_end;

   assign bit_end = (div_q == DIV_LAST);
   assign done    = (state_q == STOP) && bit_end;
   assign tx      = tx_q;
   assign state   = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         // The line follows the state one cycle later, so it is a pure flop.
         case (state_q)
            IDLE:  tx_q <= 1'b1;
            START: tx_q <= 1'b0;
            DATA:  tx_q <= shift_q[0];
            STOP:  tx_q <= 1'b1;
         endcase

         div_q <= bit_end ? '0 : div_q + 1'b1;

         case (state_q)
            IDLE: begin
               div_q <= '0;
               bit_q <= '0;
               if (start) begin
                  state_q <= START;
                  shift_q <= byte_in;
               end
            end
            START: begin
               if (bit_end) state_q <= DATA;
            end
            DATA: begin
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= STOP;
               end
            end
            STOP: begin
               // Chaining here keeps the next start bit flush with this stop bit.
               if (bit_end) begin
                  if (start) begin
                     state_q <= START;
                     shift_q <= byte_in;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/qam_uart_framer.sv
// rtl/qam_uart_framer.sv - buffers filtered I/Q pairs and sends each as a 5-byte UART frame
//
// Purpose : FIFO for I/Q pairs, frame byte sequencing and overflow flag.
// Ports   : clk            - system clock
//           reset          - synchronous active-high reset
//           i_data, q_data - signed samples, DATA_W bits
//           sample_valid   - one-cycle strobe qualifying i_data/q_data
//           ovf_clr        - clears the sticky overflow flag
//           tx_output_uart - UART 8N1 serial output, idles high
//           busy           - high while a frame is on the line
//           overflow       - sticky, set when a pair is dropped
//           fifo_level     - current FIFO occupancy
module qam_uart_framer
   import qam_uart_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 2604
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_W-1:0]           i_data,
   input  logic [DATA_W-1:0]           q_data,
   input  logic                        sample_valid,
   input  logic                        ovf_clr,
   output logic                        tx_output_uart,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam int             LW       = AW + 1;
   localparam logic [LW-1:0]  DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [2:0]     LAST_IDX = 3'(BYTES_PER_FRAME - 1);

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   frame_q, frame_d;
   logic [2:0]    byte_idx_q, byte_idx_d;

   logic          push, pop, drop;
   logic [31:0]   pair_in;
   tx_state_e     tx_state;
   logic          byte_done;
   logic          byte_start;
   logic [7:0]    byte_data;

   assign pair_in = {sext16(16'(i_data), DATA_W), sext16(16'(q_data), DATA_W)};

   always_comb begin
      pop  = (tx_state == IDLE) && (level_q != '0);
      // A full FIFO still accepts when the head leaves in the same cycle.
      push = sample_valid && ((level_q != DEPTH_L) || pop);
      drop = sample_valid && !push;

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end

      ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

      frame_d = pop ? mem_q[rd_ptr_q] : frame_q;

      // byte_idx_q names the byte currently on the line; on its done the
      // next byte of the frame is chained in.
      byte_start = pop || (byte_done && (byte_idx_q != LAST_IDX));
      byte_idx_d = byte_idx_q;
      if (pop) begin
         byte_idx_d = 3'd0;
      end else if (byte_done) begin
         byte_idx_d = (byte_idx_q == LAST_IDX) ? 3'd0 : byte_idx_q + 1'b1;
      end

      // The sync byte is sent before frame_q has been loaded, so it is a constant.
      byte_data = SYNC_BYTE;
      if (!pop) begin
         case (byte_idx_q)
            3'd0:    byte_data = frame_q[31:24];
            3'd1:    byte_data = frame_q[23:16];
            3'd2:    byte_data = frame_q[15:8];
            default: byte_data = frame_q[7:0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pair_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         frame_q    <= '0;
         byte_idx_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         frame_q    <= frame_d;
         byte_idx_q <= byte_idx_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk     (clk),
      .reset   (reset),
      .start   (byte_start),
      .byte_in (byte_data),
      .tx      (tx_output_uart),
      .done    (byte_done),
      .state   (tx_state)
   );

   assign busy       = (tx_state != IDLE);
   assign overflow   = ovf_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_qam_uart_framer.sv
// tb/tb_qam_uart_framer.sv - self-checking bench for qam_uart_framer
module tb_qam_uart_framer;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] i0, q0;
   logic [11:0] i1, q1;
   logic        sv0, sv1, clr0, clr1;
   logic        tx_w   [2];
   logic        busy_w [2];
   logic        ovf_w  [2];
   logic [3:0]  lvl0, lvl1;

   always #5 clk = ~clk;

   qam_uart_framer #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .i_data(i0), .q_data(q0), .sample_valid(sv0),
      .ovf_clr(clr0), .tx_output_uart(tx_w[0]), .busy(busy_w[0]),
      .overflow(ovf_w[0]), .fifo_level(lvl0)
   );

   qam_uart_framer #(.DATA_W(12), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut12 (
      .clk(clk), .reset(reset), .i_data(i1), .q_data(q1), .sample_valid(sv1),
      .ovf_clr(clr1), .tx_output_uart(tx_w[1]), .busy(busy_w[1]),
      .overflow(ovf_w[1]), .fifo_level(lvl1)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx0[$], rx1[$], exp0[$], exp1[$];
   logic       rx_act [2];
   int         rx_pos [2];
   logic [7:0] rx_sh  [2];
   int         stop_err = 0;

   // UART receiver: samples each bit in its middle, counted from the first low sample.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (reset) begin
            rx_act[u] <= 1'b0;
         end else if (!rx_act[u]) begin
            if (tx_w[u] === 1'b0) begin
               rx_act[u] <= 1'b1;
               rx_pos[u] <= 1;
            end
         end else begin
            rx_pos[u] <= rx_pos[u] + 1;
            if (rx_pos[u] % CPB == CPB / 2) begin
               if (rx_pos[u] / CPB >= 1 && rx_pos[u] / CPB <= 8)
                  rx_sh[u][rx_pos[u] / CPB - 1] <= tx_w[u];
               if (rx_pos[u] / CPB == 9) begin
                  if (tx_w[u] !== 1'b1) stop_err <= stop_err + 1;
                  if (u == 0) rx0.push_back(rx_sh[u]);
                  else        rx1.push_back(rx_sh[u]);
                  rx_act[u] <= 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sx(input int v, input int w);
      int s;
      s = (v >= (1 << (w - 1))) ? v - (1 << w) : v;
      return 16'(s);
   endfunction

   function automatic int peak_exp(input int n);
      int p;
      p = (n - 1 < 1) ? 1 : n - 1;
      return (p > DEPTH) ? DEPTH : p;
   endfunction

   function automatic int lvl_of(input int u);
      return (u == 0) ? int'(lvl0) : int'(lvl1);
   endfunction

   task automatic model_frame(input int u, input int iv, input int qv);
      logic [15:0] ie, qe;
      int w;
      w  = (u == 0) ? 16 : 12;
      ie = sx(iv, w);
      qe = sx(qv, w);
      if (u == 0) begin
         exp0.push_back(8'hA5); exp0.push_back(ie[15:8]); exp0.push_back(ie[7:0]);
         exp0.push_back(qe[15:8]); exp0.push_back(qe[7:0]);
      end else begin
         exp1.push_back(8'hA5); exp1.push_back(ie[15:8]); exp1.push_back(ie[7:0]);
         exp1.push_back(qe[15:8]); exp1.push_back(qe[7:0]);
      end
   endtask

   task automatic set_inputs(input int u, input int iv, input int qv, input logic v, input logic c);
      if (u == 0) begin
         i0 = 16'(iv); q0 = 16'(qv); sv0 = v; clr0 = c;
      end else begin
         i1 = 12'(iv); q1 = 12'(qv); sv1 = v; clr1 = c;
      end
   endtask

   // n back-to-back strobes from an idle, empty framer: the first pair leaves
   // at once, so only DEPTH more fit before pairs are dropped.
   task automatic burst(input int u, input int n, input logic clr_last, output int peak);
      int iv, qv, lim;
      peak = 0;
      lim  = (u == 0) ? 65535 : 4095;
      for (int k = 0; k < n; k++) begin
         iv = int'($urandom_range(0, lim));
         qv = int'($urandom_range(0, lim));
         set_inputs(u, iv, qv, 1'b1, clr_last && (k == n - 1));
         tick();
         if (k < DEPTH + 1) model_frame(u, iv, qv);
         if (lvl_of(u) > peak) peak = lvl_of(u);
      end
      set_inputs(u, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int u, input string tag);
      logic       done;
      logic [7:0] got[$], want[$];
      done = 1'b0;
      for (int n = 0; n < 20000 && !done; n++) begin
         tick();
         if (!busy_w[u] && lvl_of(u) == 0 && !rx_act[u]) done = 1'b1;
      end
      repeat (3) tick();
      chk({tag, " drain"}, 32'(done), 32'd1);
      if (u == 0) begin
         got = rx0; want = exp0; rx0.delete(); exp0.delete();
      end else begin
         got = rx1; want = exp1; rx1.delete(); exp1.delete();
      end
      chk({tag, " byte_count"}, got.size(), want.size());
      for (int i = 0; i < got.size() && i < want.size(); i++)
         chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(want[i]));
      chk({tag, " stop_bits"}, stop_err, 0);
   endtask

   task automatic clr_pulse(input int u);
      set_inputs(u, 0, 0, 1'b0, 1'b1);
      tick();
      set_inputs(u, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      int peak, busy_cnt, u, n;
      set_inputs(0, 0, 0, 1'b0, 1'b0);
      set_inputs(1, 0, 0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_tx%0d", k), 32'(tx_w[k]), 32'd1);
         chk($sformatf("rst_busy%0d", k), 32'(busy_w[k]), 32'd0);
         chk($sformatf("rst_ovf%0d", k), 32'(ovf_w[k]), 32'd0);
         chk($sformatf("rst_level%0d", k), lvl_of(k), 0);
      end
      reset = 1'b0;
      tick();

      // Basic frame with latency and busy length
      set_inputs(0, 'h1234, 'hFFFE, 1'b1, 1'b0);
      model_frame(0, 'h1234, 'hFFFE);
      tick();
      chk("lat_level_n", lvl_of(0), 1);
      chk("lat_busy_n", 32'(busy_w[0]), 32'd0);
      chk("lat_tx_n", 32'(tx_w[0]), 32'd1);
      set_inputs(0, 0, 0, 1'b0, 1'b0);
      tick();
      chk("lat_busy_n1", 32'(busy_w[0]), 32'd1);
      chk("lat_tx_n1", 32'(tx_w[0]), 32'd1);
      chk("lat_level_n1", lvl_of(0), 0);
      tick();
      chk("lat_tx_n2", 32'(tx_w[0]), 32'd0);
      busy_cnt = 2;
      for (int k = 0; k < 1000 && busy_w[0]; k++) begin
         tick();
         if (busy_w[0]) busy_cnt++;
      end
      chk("busy_len", busy_cnt, 50 * CPB);
      drain(0, "basic");

      // Sign extension on the 12-bit instance
      set_inputs(1, 'h800, 'h7FF, 1'b1, 1'b0);
      model_frame(1, 'h800, 'h7FF);
      tick();
      set_inputs(1, 0, 0, 1'b0, 1'b0);
      drain(1, "sext");

      // Burst fill: 9 strobes, nothing dropped
      burst(0, 9, 1'b0, peak);
      chk("fill_peak", peak, peak_exp(9));
      chk("fill_ovf", 32'(ovf_w[0]), 32'd0);
      drain(0, "fill");
      chk("fill_ovf_end", 32'(ovf_w[0]), 32'd0);

      // Overflow: 10 strobes, last dropped
      burst(0, 10, 1'b0, peak);
      chk("ovf_set", 32'(ovf_w[0]), 32'd1);
      drain(0, "ovf");
      chk("ovf_sticky", 32'(ovf_w[0]), 32'd1);
      clr_pulse(0);
      chk("ovf_clear", 32'(ovf_w[0]), 32'd0);

      // Clear coinciding with a drop
      burst(0, 10, 1'b1, peak);
      chk("set_wins", 32'(ovf_w[0]), 32'd1);
      drain(0, "setwins");
      clr_pulse(0);
      chk("set_wins_clear", 32'(ovf_w[0]), 32'd0);

      // Randomized bursts on either instance
      repeat (4) begin
         u = int'($urandom_range(0, 1));
         n = int'($urandom_range(1, 10));
         burst(u, n, 1'b0, peak);
         chk($sformatf("rand_peak u%0d n%0d", u, n), peak, peak_exp(n));
         drain(u, $sformatf("rand u%0d n%0d", u, n));
         chk($sformatf("rand_ovf u%0d n%0d", u, n), 32'(ovf_w[u]), 32'(n > DEPTH + 1));
         clr_pulse(u);
      end

      // Reset during DATA of byte 2, with a second pair waiting in the FIFO
      set_inputs(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b1, 1'b0);
      tick();
      set_inputs(0, 0, 0, 1'b0, 1'b0);
      repeat (4) tick();
      set_inputs(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b1, 1'b0);
      tick();
      set_inputs(0, 0, 0, 1'b0, 1'b0);
      chk("pre_rst_level", lvl_of(0), 1);
      repeat (87) tick();
      chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
      reset = 1'b1;
      tick();
      chk("mid_rst_tx", 32'(tx_w[0]), 32'd1);
      chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
      chk("mid_rst_level", lvl_of(0), 0);
      reset = 1'b0;
      rx0.delete();
      exp0.delete();
      tick();
      burst(0, 1, 1'b0, peak);
      drain(0, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qam_uart_framer.md
Name: qam_uart_framer

Overview:
Downstream consumer of the QAM-16 receive filter outputs. It accepts filtered I/Q sample pairs qualified by the FIR valid strobe and buffers them in a small FIFO. Each pair is packed into a fixed 5-byte frame and serialised as UART 8N1 on tx_output_uart for capture by the host. It absorbs bursts from the filter chain, which runs faster than the serial line.

Parameters:
DATA_W, 16, width of I and Q samples; legal range 9..16; values are sign-extended to 16 bits before packing
FIFO_DEPTH, 8, number of I/Q pairs buffered; power of two, at least 2
CLKS_PER_BIT, 2604, clk cycles per UART bit (50 MHz / 19200 baud); minimum 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
i_data  input  DATA_W  signed in-phase sample from the FIR stage
q_data  input  DATA_W  signed quadrature sample from the FIR stage
sample_valid  input  1  one-cycle strobe (FIRO_VALID); I/Q are valid in this cycle
ovf_clr  input  1  clears the overflow flag
tx_output_uart  output  1  UART serial out; idles high
busy  output  1  high while a frame is being shifted out
overflow  output  1  sticky flag; high once a sample has been dropped
fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset state: tx_output_uart=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame. tx_output_uart is high from the cycle after the reset edge, and FIFO contents are discarded.
- Push: occurs when sample_valid=1 and either (level<FIFO_DEPTH) or a pop happens in the same cycle. Both samples are stored as a sign-extended {I16,Q16} pair.
- Drop: occurs when sample_valid=1, the FIFO is full and there is no same-cycle pop. The pair is discarded and overflow is set on that edge.
- overflow is cleared by ovf_clr. If ovf_clr and a drop occur in the same cycle, overflow stays 1 (set wins).
- Pop: occurs when FSM=IDLE and level>0. The head pair is loaded into the frame register and the FSM moves to START.
- Simultaneous push and pop leaves level unchanged.
- Frame byte order: 0xA5 sync, I[15:8], I[7:0], Q[15:8], Q[7:0].
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE -> START on pop.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) if byte_idx<4, else STOP -> IDLE.
- No gap between bytes within a frame. There is exactly one IDLE cycle between frames.
- Frame length is 50*CLKS_PER_BIT cycles; back-to-back frame period is 50*CLKS_PER_BIT+1 cycles.
- busy=1 in START, DATA and STOP; busy=0 in IDLE.
- Latency: a pair pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx_output_uart goes low from edge N+2.
- tx_output_uart is a registered output with no combinational path from any input.
- Bit counter and clock divider wrap to 0 at every bit boundary.
- byte_idx runs 0..4 and resets to 0 when the FSM returns to IDLE.

Decomposition:
- Package qam_uart_pkg holds:
  - SYNC_BYTE = 8'hA5
  - BYTES_PER_FRAME = 5
  - the FSM state enum (IDLE, START, DATA, STOP)
  - the sign-extension helper function
- One sub-module, uart_tx_byte, handles the per-byte 8N1 shifter with CLKS_PER_BIT. It takes a byte plus a start strobe and returns done.
- The framer holds the FIFO, byte sequencing and the flags.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, one strobe with I=16'h1234, Q=16'hFFFE -> the decoded bytes are A5,12,34,FF,FE. tx goes low 2 cycles after the strobe; busy is high for 200 cycles; fifo_level returns to 0.
- Sign extension: DATA_W=12, I=12'h800, Q=12'h7FF -> the bytes are A5,F8,00,07,FF.
- Burst fill: 9 consecutive strobes from empty -> 9 frames are output in order, overflow stays 0, and the peak fifo_level is 8.
- Overflow: 10 consecutive strobes from empty -> the 10th pair is dropped, overflow=1, and exactly 9 frames are sent. A later ovf_clr pulse clears overflow to 0.
- Set-wins: ovf_clr asserted in the same cycle as a drop -> overflow remains 1.
- Reset mid-frame: assert reset during the DATA state of byte 2 -> tx=1, busy=0 and fifo_level=0 on the next cycle. A new strobe afterwards produces a clean full frame.
